// File: rtl/spi_tx_master.sv
// spi_tx_master: pops bytes from the FIFO and shifts them out MSB-first on SPI mode 0.
// Optional receive capture on miso is enabled by defining SPI_MISO_CAPTURE_EN.
module spi_tx_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       spi_clk,
    input  logic       rst,
    input  logic       fifo_e,
    input  logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic       busy,
    output logic       done
`ifdef SPI_MISO_CAPTURE_EN
    ,
    input  logic       miso,
    output logic [7:0] miso_data,
    output logic       miso_valid
`endif
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, GAP} state_t;
    state_t state, state_nxt;
    logic [7:0] shreg, div_cnt;
    logic [3:0] edge_cnt;
    logic wrap, fall, last;
    assign wrap = div_cnt == 8'(CLK_DIV - 1);
    assign fall = state == SHIFT && wrap && sclk;
    assign last = fall && edge_cnt == 4'd15;
    assign busy = state != IDLE;
    always_ff @(posedge spi_clk) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = fifo_e ? IDLE : FETCH;
            FETCH:   state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   state_nxt = last ? GAP : SHIFT;
            GAP:     state_nxt = wrap ? IDLE : GAP;
            default: state_nxt = IDLE;
        endcase
    end
    // shreg rotates so all of it stays live; only 7 shifts happen per frame
    always_ff @(posedge spi_clk) begin
        if (rst) begin
            rx_ready <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
            done     <= 1'b0;
            shreg    <= 8'd0;
            div_cnt  <= 8'd0;
            edge_cnt <= 4'd0;
        end else begin
            rx_ready <= state_nxt == FETCH;
            done     <= last;
            case (state)
                IDLE: begin
                    cs_n    <= 1'b1;
                    sclk    <= 1'b0;
                    div_cnt <= 8'd0;
                end
                LOAD: begin
                    shreg    <= rx_data;
                    mosi     <= rx_data[7];
                    cs_n     <= 1'b0;
                    div_cnt  <= 8'd0;
                    edge_cnt <= 4'd0;
                end
                SHIFT: begin
                    div_cnt <= wrap ? 8'd0 : div_cnt + 8'd1;
                    if (wrap) begin
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + 4'd1;
                    end
                    if (fall && !last) begin
                        shreg <= {shreg[6:0], shreg[7]};
                        mosi  <= shreg[6];
                    end
                end
                GAP: begin
                    cs_n    <= 1'b1;
                    sclk    <= 1'b0;
                    mosi    <= 1'b0;
                    div_cnt <= wrap ? 8'd0 : div_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end
`ifdef SPI_MISO_CAPTURE_EN
    logic [7:0] rx_shreg;
    always_ff @(posedge spi_clk) begin
        if (rst) begin
            rx_shreg   <= 8'd0;
            miso_data  <= 8'd0;
            miso_valid <= 1'b0;
        end else begin
            if (state == SHIFT && wrap && !sclk) rx_shreg <= {rx_shreg[6:0], miso};
            if (last) miso_data <= rx_shreg;
            miso_valid <= last;
        end
    end
`endif
endmodule

// File: tb/tb_spi_tx_master.sv
// tb_spi_tx_master: directed self-checking bench for spi_tx_master
module tb_spi_tx_master;
    logic spi_clk = 1'b0, rst = 1'b1;
    logic fifo_e, rx_ready, sclk, mosi, cs_n, busy, done;
    logic [7:0] rx_data = 8'd0;
    logic fifo_e1 = 1'b1;
    logic [7:0] rx_data1 = 8'd0;
    logic rx_ready1, sclk1, mosi1, cs_n1, busy1, done1;
    logic [7:0] fmem [8];
    int wr = 0, rd = 0, cyc = 0, total = 0, bad = 0;
    int n_rise, n_rdy, n_pop, n_done, n_done_bad, n_busy, n_cs_low, n_csf;
    int t_fetch, t_idle, t_cs_rise, t_rise1;
    int t_cs_fall [2];
    logic [15:0] bits;
`ifdef SPI_MISO_CAPTURE_EN
    logic [7:0] miso_data, miso_data1, mv_data;
    logic miso_valid, miso_valid1;
    int n_mv, n_mv_bad;
`endif

    assign fifo_e = (wr == rd);
    always #5 spi_clk = ~spi_clk;

    always @(posedge spi_clk) begin
        cyc <= cyc + 1;
        if (rx_ready && !fifo_e) begin
            rx_data <= fmem[rd % 8];
            rd <= rd + 1;
        end
    end

    spi_tx_master #(.CLK_DIV(4)) dut (
        .spi_clk(spi_clk), .rst(rst), .fifo_e(fifo_e), .rx_data(rx_data),
        .rx_ready(rx_ready), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy), .done(done)
`ifdef SPI_MISO_CAPTURE_EN
        , .miso(mosi), .miso_data(miso_data), .miso_valid(miso_valid)
`endif
    );

    spi_tx_master #(.CLK_DIV(1)) dut1 (
        .spi_clk(spi_clk), .rst(rst), .fifo_e(fifo_e1), .rx_data(rx_data1),
        .rx_ready(rx_ready1), .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1), .busy(busy1), .done(done1)
`ifdef SPI_MISO_CAPTURE_EN
        , .miso(mosi1), .miso_data(miso_data1), .miso_valid(miso_valid1)
`endif
    );

    task automatic push(input logic [7:0] b);
        fmem[wr % 8] = b;
        wr++;
    endtask

    task automatic observe(input int n);
        logic ps, pc;
        ps = sclk; pc = cs_n;
        n_rise = 0; n_rdy = 0; n_pop = 0; n_done = 0; n_done_bad = 0; n_busy = 0;
        n_cs_low = 0; n_csf = 0; bits = 16'd0;
        t_fetch = -1; t_idle = -1; t_cs_rise = -1; t_rise1 = -1;
        t_cs_fall[0] = -1; t_cs_fall[1] = -1;
`ifdef SPI_MISO_CAPTURE_EN
        n_mv = 0; n_mv_bad = 0; mv_data = 8'd0;
`endif
        repeat (n) begin
            @(negedge spi_clk);
            if (sclk && !ps) begin
                n_rise++;
                bits = {bits[14:0], mosi};
                if (t_rise1 < 0) t_rise1 = cyc;
            end
            if (rx_ready) begin
                n_rdy++;
                if (t_fetch < 0) t_fetch = cyc;
            end
            if (rx_ready && !fifo_e) n_pop++;
            if (done) begin
                n_done++;
                if (sclk || !ps) n_done_bad++;
            end
            if (busy) n_busy++;
            if (!busy && t_fetch >= 0 && t_idle < 0) t_idle = cyc;
            if (!cs_n) n_cs_low++;
            if (!cs_n && pc && n_csf < 2) begin
                t_cs_fall[n_csf] = cyc;
                n_csf++;
            end
            if (cs_n && !pc && t_cs_rise < 0) t_cs_rise = cyc;
`ifdef SPI_MISO_CAPTURE_EN
            if (miso_valid) begin
                n_mv++;
                mv_data = miso_data;
            end
            if (miso_valid !== done) n_mv_bad++;
`endif
            ps = sclk; pc = cs_n;
        end
    endtask

    task automatic test_reset;
        push(8'h77);
        for (int i = 0; i < 3; i++) begin
            @(negedge spi_clk);
            total++;
            if ({cs_n, sclk, mosi, rx_ready, busy} !== 5'b10000) begin
                bad++;
                $display("FAIL reset_outputs cycle %0d got=%b exp=10000", i, {cs_n, sclk, mosi, rx_ready, busy});
            end
        end
        wr = rd;
        rst = 1'b0;
    endtask

    task automatic test_empty;
        observe(200);
        total++; if (n_rdy !== 0) begin bad++; $display("FAIL empty_rx_ready got=%0d exp=0", n_rdy); end
        total++; if (n_cs_low !== 0) begin bad++; $display("FAIL empty_cs_low got=%0d exp=0", n_cs_low); end
        total++; if (n_busy !== 0) begin bad++; $display("FAIL empty_busy got=%0d exp=0", n_busy); end
    endtask

    task automatic test_single;
        int tp;
        push(8'hA5);
        tp = cyc;
        observe(100);
        total++; if (n_rdy !== 1) begin bad++; $display("FAIL single_rdy_cycles got=%0d exp=1", n_rdy); end
        total++; if (n_pop !== 1) begin bad++; $display("FAIL single_pops got=%0d exp=1", n_pop); end
        total++; if (n_rise !== 8) begin bad++; $display("FAIL single_sclk_pulses got=%0d exp=8", n_rise); end
        total++; if (bits[7:0] !== 8'hA5) begin bad++; $display("FAIL single_bits got=%h exp=a5", bits[7:0]); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL single_done_count got=%0d exp=1", n_done); end
        total++; if (n_done_bad !== 0) begin bad++; $display("FAIL single_done_align got=%0d exp=0", n_done_bad); end
        total++; if (t_fetch - tp !== 1) begin bad++; $display("FAIL single_fetch_latency got=%0d exp=1", t_fetch - tp); end
        total++; if (t_idle - t_fetch !== 70) begin bad++; $display("FAIL single_frame_len got=%0d exp=70", t_idle - t_fetch); end
        total++; if (t_cs_fall[0] - t_fetch !== 2) begin bad++; $display("FAIL single_cs_fall got=%0d exp=2", t_cs_fall[0] - t_fetch); end
        total++; if (t_rise1 - t_cs_fall[0] !== 4) begin bad++; $display("FAIL single_first_rise got=%0d exp=4", t_rise1 - t_cs_fall[0]); end
    endtask

    task automatic test_back_to_back;
        push(8'h00);
        push(8'hFF);
        observe(180);
        total++; if (n_pop !== 2) begin bad++; $display("FAIL b2b_pops got=%0d exp=2", n_pop); end
        total++; if (n_rise !== 16) begin bad++; $display("FAIL b2b_sclk_pulses got=%0d exp=16", n_rise); end
        total++; if (bits !== 16'h00FF) begin bad++; $display("FAIL b2b_bits got=%h exp=00ff", bits); end
        total++; if (n_done !== 2) begin bad++; $display("FAIL b2b_done_count got=%0d exp=2", n_done); end
        total++; if (t_cs_fall[1] - t_cs_rise !== 6) begin bad++; $display("FAIL b2b_cs_gap got=%0d exp=6", t_cs_fall[1] - t_cs_rise); end
        total++; if (fifo_e !== 1'b1) begin bad++; $display("FAIL b2b_fifo_empty got=%b exp=1", fifo_e); end
        total++; if (mosi !== 1'b0) begin bad++; $display("FAIL b2b_idle_mosi got=%b exp=0", mosi); end
    endtask

    task automatic test_reset_mid;
        int r;
        logic ps;
        push(8'h5A);
        r = 0;
        ps = sclk;
        for (int i = 0; i < 100 && r < 3; i++) begin
            @(negedge spi_clk);
            if (sclk && !ps) r++;
            ps = sclk;
        end
        total++; if (r !== 3) begin bad++; $display("FAIL mid_wait_rises got=%0d exp=3", r); end
        rst = 1'b1;
        @(negedge spi_clk);
        total++;
        if ({cs_n, sclk, mosi, rx_ready, busy, done} !== 6'b100000) begin
            bad++;
            $display("FAIL mid_reset_outputs got=%b exp=100000", {cs_n, sclk, mosi, rx_ready, busy, done});
        end
        rst = 1'b0;
        observe(80);
        total++; if (n_done !== 0) begin bad++; $display("FAIL mid_no_done got=%0d exp=0", n_done); end
        total++; if (n_busy !== 0) begin bad++; $display("FAIL mid_stays_idle got=%0d exp=0", n_busy); end
        push(8'h3C);
        observe(100);
        total++; if (bits[7:0] !== 8'h3C) begin bad++; $display("FAIL mid_next_bits got=%h exp=3c", bits[7:0]); end
        total++; if (n_rise !== 8) begin bad++; $display("FAIL mid_next_pulses got=%0d exp=8", n_rise); end
        total++; if (n_done !== 1) begin bad++; $display("FAIL mid_next_done got=%0d exp=1", n_done); end
        total++; if (n_pop !== 1) begin bad++; $display("FAIL mid_next_pops got=%0d exp=1", n_pop); end
    endtask

`ifdef SPI_MISO_CAPTURE_EN
    task automatic test_miso;
        push(8'h3C);
        observe(100);
        total++; if (n_mv !== 1) begin bad++; $display("FAIL miso_valid_count got=%0d exp=1", n_mv); end
        total++; if (mv_data !== 8'h3C) begin bad++; $display("FAIL miso_data got=%h exp=3c", mv_data); end
        total++; if (n_mv_bad !== 0) begin bad++; $display("FAIL miso_valid_align got=%0d exp=0", n_mv_bad); end
    endtask
`endif

    task automatic test_clkdiv1;
        int r, nd, rdy, tf, ti;
        logic ps;
        logic [7:0] b;
        r = 0; nd = 0; rdy = 0; tf = -1; ti = -1; b = 8'd0;
        rx_data1 = 8'hC3;
        ps = sclk1;
        fifo_e1 = 1'b0;
        repeat (40) begin
            @(negedge spi_clk);
            if (rx_ready1) begin
                rdy++;
                if (tf < 0) tf = cyc;
            end
            if (tf >= 0 && cyc == tf + 1) fifo_e1 = 1'b1;
            if (sclk1 && !ps) begin
                r++;
                b = {b[6:0], mosi1};
            end
            if (done1) nd++;
            if (tf >= 0 && !busy1 && ti < 0) ti = cyc;
            ps = sclk1;
        end
        total++; if (rdy !== 1) begin bad++; $display("FAIL div1_rdy_cycles got=%0d exp=1", rdy); end
        total++; if (r !== 8) begin bad++; $display("FAIL div1_sclk_pulses got=%0d exp=8", r); end
        total++; if (b !== 8'hC3) begin bad++; $display("FAIL div1_bits got=%h exp=c3", b); end
        total++; if (nd !== 1) begin bad++; $display("FAIL div1_done_count got=%0d exp=1", nd); end
        total++; if (ti - tf !== 19) begin bad++; $display("FAIL div1_frame_len got=%0d exp=19", ti - tf); end
    endtask

    initial begin
        test_reset;
        test_empty;
        test_single;
        test_back_to_back;
        test_reset_mid;
`ifdef SPI_MISO_CAPTURE_EN
        test_miso;
`endif
        test_clkdiv1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
